pc_branch_unit: RTL and testbench

PC_BRANCH_UNIT -- requirements
Module: pc_branch_unit

---
 rtl/pc_branch_unit.sv | 143 ++++++++++++++
 tb/tb_pc_branch_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pc_branch_unit.sv
// Purpose : program counter with sequential/branch/jump/return redirect and a circular return-address stack.
// Latency : one cycle from inputs to pc; taken and ret_underflow are registered alongside pc.
// Backpress: stall holds every piece of state; taken and ret_underflow drop to 0 while stalled.
//
// Ports:
//   clock, reset            - rising-edge clock, asynchronous active-high reset
//   stall                   - hold all state this cycle
//   branch_control_signal   - 00 seq, 01 jump branch_address, 10 conditional, 11 jump read_1
//   funct, alu_flags        - condition select and {C,N,Z} flags for mode 10
//   branch_address, read_1  - absolute and register redirect targets
//   call, ret               - push return address on a taken redirect / pop and redirect
//   pc, taken               - current PC, one-cycle pulse after a redirect
//   ras_empty, ras_overflow - stack occupancy zero (comb), sticky overwrite of a live entry
//   ret_underflow           - one-cycle pulse after a ret on an empty stack
module pc_branch_unit #(
  parameter int unsigned             ADDR_W    = 32,
  parameter int unsigned             RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0]       RESET_PC  = '0,
  parameter logic [ADDR_W-1:0]       PC_STEP   = ADDR_W'(4)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        branch_control_signal,
  input  logic [2:0]        funct,
  input  logic [2:0]        alu_flags,
  input  logic [ADDR_W-1:0] branch_address,
  input  logic [ADDR_W-1:0] read_1,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_overflow,
  output logic              ret_underflow
);

  localparam int unsigned    PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL  = (PTR_W+1)'(RAS_DEPTH);

  logic [ADDR_W-1:0] r_pc;
  logic              r_taken;
  logic              r_ras_overflow;
  logic              r_ret_underflow;
  // r_ptr is the next write slot; the top of stack lives at r_ptr - 1.
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W:0]    r_count;
  logic [ADDR_W-1:0] r_stack [RAS_DEPTH];

  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_br_target;
  logic [ADDR_W-1:0] w_top;
  logic [ADDR_W-1:0] w_next_pc;
  logic [PTR_W-1:0]  w_top_ptr;
  logic              w_zf, w_nf, w_cf;
  logic              w_cond;
  logic              w_br_taken;
  logic              w_pop;
  logic              w_underflow;
  logic              w_push;
  logic              w_full;

  assign w_zf = alu_flags[0];
  assign w_nf = alu_flags[1];
  assign w_cf = alu_flags[2];

  assign w_seq_pc  = r_pc + PC_STEP;
  assign w_top_ptr = r_ptr - PTR_W'(1);
  assign w_top     = r_stack[w_top_ptr];
  assign w_full    = (r_count == FULL);

  always_comb begin
    w_cond = 1'b0;
    case (funct)
      3'b000:  w_cond = w_zf;
      3'b001:  w_cond = ~w_zf;
      3'b010:  w_cond = w_nf;
      3'b011:  w_cond = ~w_nf;
      3'b100:  w_cond = w_cf;
      3'b101:  w_cond = ~w_cf;
      3'b110:  w_cond = w_nf | w_zf;
      default: w_cond = 1'b1;
    endcase
  end

  assign w_br_taken  = (branch_control_signal == 2'b01) ||
                       (branch_control_signal == 2'b11) ||
                       ((branch_control_signal == 2'b10) && w_cond);
  assign w_br_target = (branch_control_signal == 2'b11) ? read_1 : branch_address;

  // ret outranks any branch; a ret on an empty stack degrades to sequential.
  assign w_pop       = ret && (r_count != '0);
  assign w_underflow = ret && (r_count == '0);
  assign w_push      = !ret && call && w_br_taken;

  always_comb begin
    w_next_pc = w_seq_pc;
    if (ret) begin
      if (w_pop) w_next_pc = w_top;
    end else if (w_br_taken) begin
      w_next_pc = w_br_target;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc            <= RESET_PC;
      r_taken         <= 1'b0;
      r_ret_underflow <= 1'b0;
      r_ras_overflow  <= 1'b0;
      r_ptr           <= '0;
      r_count         <= '0;
    end else if (stall) begin
      r_taken         <= 1'b0;
      r_ret_underflow <= 1'b0;
    end else begin
      r_pc            <= w_next_pc;
      r_taken         <= w_pop || (!ret && w_br_taken);
      r_ret_underflow <= w_underflow;
      if (w_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        // A push into a full stack overwrites the oldest entry (the slot at r_ptr).
        if (w_full) r_ras_overflow <= 1'b1;
        else        r_count        <= r_count + (PTR_W+1)'(1);
      end else if (w_pop) begin
        r_ptr   <= w_top_ptr;
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  // Entries are not reset: a zero count makes stale contents unreachable.
  always_ff @(posedge clock) begin
    if (!reset && !stall && w_push) r_stack[r_ptr] <= w_seq_pc;
  end

  assign pc            = r_pc;
  assign taken         = r_taken;
  assign ras_empty     = (r_count == '0);
  assign ras_overflow  = r_ras_overflow;
  assign ret_underflow = r_ret_underflow;

endmodule

// File: tb/tb_pc_branch_unit.sv
module tb_pc_branch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  branch_control_signal;
  logic [2:0]  funct;
  logic [2:0]  alu_flags;
  logic [31:0] branch_address;
  logic [31:0] read_1;
  logic        call;
  logic        ret;
  logic [31:0] pc;
  logic        taken;
  logic        ras_empty;
  logic        ras_overflow;
  logic        ret_underflow;

  int vectors = 0;
  int miscompares = 0;

  pc_branch_unit #(.ADDR_W(32), .RAS_DEPTH(4), .RESET_PC(32'h0), .PC_STEP(32'h4)) dut (
    .clock(clock), .reset(reset), .stall(stall),
    .branch_control_signal(branch_control_signal), .funct(funct), .alu_flags(alu_flags),
    .branch_address(branch_address), .read_1(read_1), .call(call), .ret(ret),
    .pc(pc), .taken(taken), .ras_empty(ras_empty), .ras_overflow(ras_overflow),
    .ret_underflow(ret_underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check pc plus the pulse/flag outputs in one go.
  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_tk,
                           input logic e_emp, input logic e_ovf, input logic e_und);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".taken"}, {31'd0, taken}, {31'd0, e_tk});
    check({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, e_emp});
    check({tag, ".ras_overflow"}, {31'd0, ras_overflow}, {31'd0, e_ovf});
    check({tag, ".ret_underflow"}, {31'd0, ret_underflow}, {31'd0, e_und});
  endtask

  task automatic drive(input logic [1:0] mode, input logic [2:0] f, input logic [2:0] fl,
                       input logic [31:0] tgt, input logic c, input logic r);
    branch_control_signal = mode;
    funct = f;
    alu_flags = fl;
    branch_address = tgt;
    call = c;
    ret = r;
  endtask

  // Wait for the next rising edge, then sample 1 ns later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    read_1 = 32'h0;
    drive(2'b00, 3'b000, 3'b000, 32'h0, 1'b0, 1'b0);
    #2;
    check_all("reset", 32'h0, 0, 1, 0, 0);
    #10;                      // t=12, between edges
    reset = 1'b0;
    check_all("post_reset", 32'h0, 0, 1, 0, 0);

    // Sequential run
    tick(); check_all("seq1", 32'h4, 0, 1, 0, 0);
    tick(); check_all("seq2", 32'h8, 0, 1, 0, 0);
    tick(); check_all("seq3", 32'hC, 0, 1, 0, 0);
    tick(); check_all("seq4", 32'h10, 0, 1, 0, 0);

    // Conditional branch, Z set -> taken
    drive(2'b10, 3'b000, 3'b001, 32'h80, 0, 0);
    tick(); check_all("beqz_taken", 32'h80, 1, 1, 0, 0);
    // Back to 0x10, then Z clear -> not taken
    drive(2'b01, 3'b000, 3'b000, 32'h10, 0, 0);
    tick(); check_all("jmp_0x10", 32'h10, 1, 1, 0, 0);
    drive(2'b10, 3'b000, 3'b000, 32'h80, 0, 0);
    tick(); check_all("beqz_not", 32'h14, 0, 1, 0, 0);
    // N|Z with N set -> taken
    drive(2'b10, 3'b110, 3'b010, 32'h40, 0, 0);
    tick(); check_all("ble_taken", 32'h40, 1, 1, 0, 0);
    // !C with C set -> not taken
    drive(2'b10, 3'b101, 3'b100, 32'h90, 0, 0);
    tick(); check_all("bnc_not", 32'h44, 0, 1, 0, 0);
    // always
    drive(2'b10, 3'b111, 3'b000, 32'h20, 0, 0);
    tick(); check_all("always", 32'h20, 1, 1, 0, 0);

    // Call then return
    drive(2'b01, 3'b000, 3'b000, 32'h100, 1, 0);
    tick(); check_all("call1", 32'h100, 1, 0, 0, 0);
    drive(2'b00, 3'b000, 3'b000, 32'h0, 0, 1);
    tick(); check_all("ret1", 32'h24, 1, 1, 0, 0);

    // Five calls into a 4-deep stack: pushes 28,304,404,504,604
    drive(2'b01, 3'b000, 3'b000, 32'h300, 1, 0); tick(); check_all("c1", 32'h300, 1, 0, 0, 0);
    drive(2'b01, 3'b000, 3'b000, 32'h400, 1, 0); tick(); check_all("c2", 32'h400, 1, 0, 0, 0);
    drive(2'b01, 3'b000, 3'b000, 32'h500, 1, 0); tick(); check_all("c3", 32'h500, 1, 0, 0, 0);
    drive(2'b01, 3'b000, 3'b000, 32'h600, 1, 0); tick(); check_all("c4", 32'h600, 1, 0, 0, 0);
    drive(2'b01, 3'b000, 3'b000, 32'h700, 1, 0); tick(); check_all("c5", 32'h700, 1, 0, 1, 0);

    drive(2'b00, 3'b000, 3'b000, 32'h0, 0, 1);
    tick(); check_all("r1", 32'h604, 1, 0, 1, 0);
    tick(); check_all("r2", 32'h504, 1, 0, 1, 0);
    tick(); check_all("r3", 32'h404, 1, 0, 1, 0);
    tick(); check_all("r4", 32'h304, 1, 1, 1, 0);
    tick(); check_all("r5_under", 32'h308, 0, 1, 1, 1);
    drive(2'b00, 3'b000, 3'b000, 32'h0, 0, 0);
    tick(); check_all("after_under", 32'h30C, 0, 1, 1, 0);

    // ret and call together: ret wins, nothing pushed
    drive(2'b01, 3'b000, 3'b000, 32'h800, 1, 0);
    tick(); check_all("call_800", 32'h800, 1, 0, 1, 0);
    drive(2'b01, 3'b000, 3'b000, 32'h900, 1, 1);
    tick(); check_all("ret_call", 32'h310, 1, 1, 1, 0);

    // Stall with mode 11: hold pc, taken drops
    read_1 = 32'h200;
    stall = 1'b1;
    drive(2'b11, 3'b000, 3'b000, 32'h0, 0, 0);
    tick(); check_all("stall", 32'h310, 0, 1, 1, 0);
    tick(); check_all("stall2", 32'h310, 0, 1, 1, 0);
    stall = 1'b0;
    tick(); check_all("jr_200", 32'h200, 1, 1, 1, 0);

    // Reset between edges with a redirect pending
    drive(2'b01, 3'b000, 3'b000, 32'hABC, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 32'h0, 0, 1, 0, 0);
    tick(); check_all("held_reset", 32'h0, 0, 1, 0, 0);
    #2;
    reset = 1'b0;
    drive(2'b00, 3'b000, 3'b000, 32'h0, 0, 0);
    tick(); check_all("first_after_reset", 32'h4, 0, 1, 0, 0);

    // Wrap-around
    drive(2'b01, 3'b000, 3'b000, 32'hFFFF_FFFC, 0, 0);
    tick(); check_all("jmp_top", 32'hFFFF_FFFC, 1, 1, 0, 0);
    drive(2'b00, 3'b000, 3'b000, 32'h0, 0, 0);
    tick(); check_all("wrap", 32'h0, 0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
